// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - mode encodings and channel limits shared by the stream multiplexers
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;
  localparam int   MAX_MUX_CH  = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant over NUM_CH requests, pointer moves only on advance
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  localparam int LEN_SEL = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CH-1:0]  req,
  input  logic               advance,
  output logic [LEN_SEL-1:0] gnt,
  output logic               gnt_vld
);

  localparam int PAD_CH = 1 << LEN_SEL;

  logic [LEN_SEL-1:0] ptr;
  logic [PAD_CH-1:0]  req_pad;
  logic [LEN_SEL-1:0] cand;
  int                 idx;

  assign req_pad = PAD_CH'(req);

  // Scan from the farthest channel back to ptr+1 so the nearest requester is written last and wins.
  always_comb begin
    gnt     = ptr;
    gnt_vld = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int k = MAX_MUX_CH; k >= 1; k--) begin
      if (k <= NUM_CH) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_CH) begin
          idx = idx - NUM_CH;
        end
        cand = idx[LEN_SEL-1:0];
        if (req_pad[cand]) begin
          gnt     = cand;
          gnt_vld = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= LEN_SEL'(NUM_CH - 1);
    end else if (advance) begin
      ptr <= gnt;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - registered N-channel stream mux, directed or round-robin selection
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter  int LEN_DATA = 256,
  parameter  int NUM_CH   = 4,
  localparam int LEN_SEL  = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mode,
  input  logic [LEN_SEL-1:0]         sel,
  input  logic [NUM_CH*LEN_DATA-1:0] in_data,
  input  logic [NUM_CH-1:0]          in_valid,
  output logic [NUM_CH-1:0]          in_ready,
  output logic [LEN_DATA-1:0]        out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LEN_SEL-1:0]         out_ch
);

  localparam int PAD_CH = 1 << LEN_SEL;

  logic [LEN_SEL-1:0]  arb_gnt;
  logic                arb_gnt_vld;
  logic [LEN_SEL-1:0]  gnt;
  logic                gnt_vld;
  logic                load;
  logic                take;
  logic [PAD_CH-1:0]   valid_pad;
  logic [LEN_DATA-1:0] gnt_data;

  // Zero-padding makes an out-of-range sel read a 0 valid bit, so it can never grant.
  assign valid_pad = PAD_CH'(in_valid);
  assign load      = !out_valid || out_ready;
  assign gnt       = (mode == MODE_DIRECT) ? sel : arb_gnt;
  assign gnt_vld   = (mode == MODE_DIRECT) ? valid_pad[sel] : arb_gnt_vld;
  assign take      = rst_n && load && gnt_vld;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .advance (take && (mode == MODE_RR)),
    .gnt     (arb_gnt),
    .gnt_vld (arb_gnt_vld)
  );

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt == LEN_SEL'(i)) begin
        in_ready[i] = take;
        gnt_data    = in_data[i*LEN_DATA +: LEN_DATA];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_ch    <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - randomized and directed checks of stream_mux_rr against a queue-based model
module tb_stream_mux_rr;
  import mux_pkg::*;

  localparam int LD = 256;
  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mode;
  logic [1:0]      sel;
  logic [NC*LD-1:0] in_data;
  logic [NC-1:0]   in_valid;
  logic [NC-1:0]   in_ready;
  logic [LD-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_ch;

  logic            mode3;
  logic [1:0]      sel3;
  logic [23:0]     in_data3;
  logic [2:0]      in_valid3;
  logic [2:0]      in_ready3;
  logic [7:0]      out_data3;
  logic            out_valid3;
  logic            out_ready3;
  logic [1:0]      out_ch3;

  stream_mux_rr dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  stream_mux_rr #(.LEN_DATA(8), .NUM_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_ch(out_ch3)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  bit          chk_en  = 1'b0;
  logic [LD-1:0] src_q [NC][$];
  logic [NC-1:0] acc_mask = '0;
  int          log_ch[$];
  logic [LD-1:0] log_data[$];
  int          log_cyc[$];

  // Model of the output register and round-robin pointer.
  logic          m_valid = 1'b0;
  logic [LD-1:0] m_data  = '0;
  int            m_ch    = 0;
  int            m_ptr   = NC - 1;

  task automatic chk(input string name, input logic [LD-1:0] act, input logic [LD-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [LD-1:0] rand256();
    logic [LD-1:0] v;
    for (int w = 0; w < LD/32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int lch(input int i);
    return (i < log_ch.size()) ? log_ch[i] : -1;
  endfunction

  function automatic logic [LD-1:0] ldat(input int i);
    return (i < log_data.size()) ? log_data[i] : '1;
  endfunction

  function automatic int lcyc(input int i);
    return (i < log_cyc.size()) ? log_cyc[i] : -100;
  endfunction

  always @(negedge clk) begin : compare
    int            g;
    bit            gv;
    bit            take_m;
    logic [NC-1:0] exp_rdy;
    cyc++;
    if (chk_en) begin
      chk("out_valid", LD'(out_valid), LD'(m_valid));
      chk("out_data", out_data, m_data);
      chk("out_ch", LD'(out_ch), LD'(m_ch));
    end
    g  = 0;
    gv = 1'b0;
    if (rst_n) begin
      if (mode == MODE_DIRECT) begin
        g  = int'(sel);
        gv = (g < NC) && in_valid[g];
      end else begin
        for (int k = 1; k <= NC; k++) begin
          if (!gv && in_valid[(m_ptr + k) % NC]) begin
            gv = 1'b1;
            g  = (m_ptr + k) % NC;
          end
        end
      end
    end
    take_m  = gv && (!m_valid || out_ready);
    exp_rdy = take_m ? (NC'(1) << g) : '0;
    if (chk_en) chk("in_ready", LD'(in_ready), LD'(exp_rdy));
    acc_mask = in_valid & in_ready;
    if (rst_n && out_valid && out_ready) begin
      log_ch.push_back(int'(out_ch));
      log_data.push_back(out_data);
      log_cyc.push_back(cyc);
    end
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_ptr   = NC - 1;
    end else if (take_m) begin
      m_valid = 1'b1;
      m_data  = in_data[g*LD +: LD];
      m_ch    = g;
      if (mode == MODE_RR) m_ptr = g;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  task automatic drive();
    for (int c = 0; c < NC; c++) begin
      in_valid[c] = (src_q[c].size() > 0);
      in_data[c*LD +: LD] = in_valid[c] ? src_q[c][0] : rand256();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    for (int c = 0; c < NC; c++) if (acc_mask[c]) void'(src_q[c].pop_front());
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int            mark;
    logic [LD-1:0] s1 [4];
    logic [LD-1:0] s3 [4];
    logic [LD-1:0] held;
    int            n1;
    int            n3;

    rst_n = 1'b0; mode = MODE_RR; sel = 2'd0; out_ready = 1'b1;
    in_valid = '0; in_data = '0;
    mode3 = MODE_DIRECT; sel3 = 2'd0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b1;

    // Reset with every channel presenting a beat.
    for (int c = 0; c < NC; c++) src_q[c].push_back(rand256());
    drive();
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    run(2);
    chk("rst_out_valid", LD'(out_valid), LD'(0));
    chk("rst_out_data", out_data, LD'(0));
    chk("rst_out_ch", LD'(out_ch), LD'(0));
    chk("rst_in_ready", LD'(in_ready), LD'(0));
    rst_n = 1'b1;
    drive();
    mark = log_ch.size();
    run(6);
    chk("rst_first_grant", LD'(lch(mark)), LD'(0));
    chk("rst_all_drained", LD'(log_ch.size() - mark), LD'(4));

    // Directed stream from channel 2.
    mode = MODE_DIRECT;
    sel  = 2'd2;
    for (int k = 0; k < 8; k++) src_q[2].push_back(LD'(32'hA0 + k));
    drive();
    mark = log_ch.size();
    run(10);
    chk("dir_count", LD'(log_ch.size() - mark), LD'(8));
    for (int k = 0; k < 8; k++) begin
      chk("dir_data", ldat(mark + k), LD'(32'hA0 + k));
      chk("dir_ch", LD'(lch(mark + k)), LD'(2));
      if (k > 0) chk("dir_gap", LD'(lcyc(mark + k) - lcyc(mark + k - 1)), LD'(1));
    end

    // Round-robin fairness with all channels valid.
    mode = MODE_RR;
    for (int c = 0; c < NC; c++) for (int k = 0; k < 3; k++) src_q[c].push_back(rand256());
    drive();
    mark = log_ch.size();
    run(15);
    for (int k = 0; k < 12; k++) chk("rr_seq", LD'(lch(mark + k)), LD'(k % 4));

    // Backpressure with channels 1 and 3.
    for (int k = 0; k < 4; k++) begin
      s1[k] = rand256();
      s3[k] = rand256();
      src_q[1].push_back(s1[k]);
      src_q[3].push_back(s3[k]);
    end
    drive();
    mark = log_ch.size();
    run(1);
    out_ready = 1'b0;
    drive();
    held = out_data;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_data_hold", out_data, s1[0]);
      chk("bp_ch_hold", LD'(out_ch), LD'(1));
      chk("bp_no_ready", LD'(in_ready), LD'(0));
    end
    chk("bp_held_first", held, s1[0]);
    out_ready = 1'b1;
    drive();
    run(10);
    chk("bp_count", LD'(log_ch.size() - mark), LD'(8));
    n1 = 0;
    n3 = 0;
    for (int k = 0; k < 8; k++) begin
      if (lch(mark + k) == 1 && n1 < 4) begin
        chk("bp_data_ch1", ldat(mark + k), s1[n1]);
        n1++;
      end else if (lch(mark + k) == 3 && n3 < 4) begin
        chk("bp_data_ch3", ldat(mark + k), s3[n3]);
        n3++;
      end
      if (k > 0) chk("bp_alternate", LD'(lch(mark + k) != lch(mark + k - 1)), LD'(1));
    end

    // Sparse requests, then a switch to directed mode mid-stream.
    mark = log_ch.size();
    src_q[3].push_back(rand256());
    drive();
    run(3);
    src_q[1].push_back(rand256());
    drive();
    run(3);
    chk("sparse_first", LD'(lch(mark)), LD'(3));
    chk("sparse_second", LD'(lch(mark + 1)), LD'(1));
    chk("sparse_ptr", LD'(dut.u_arb.ptr), LD'(1));
    for (int k = 0; k < 4; k++) begin
      src_q[0].push_back(rand256());
      src_q[2].push_back(rand256());
    end
    drive();
    mark = log_ch.size();
    run(2);
    chk("sparse_after_ptr", LD'(lch(mark)), LD'(2));
    mode = MODE_DIRECT;
    sel  = 2'd0;
    drive();
    run(1);
    chk("switch_accept", LD'(acc_mask), LD'(4'b0001));
    run(6);
    mode = MODE_RR;
    drive();
    run(8);

    // Reset while streaming at full rate.
    for (int c = 0; c < NC; c++) for (int k = 0; k < 6; k++) src_q[c].push_back(rand256());
    drive();
    run(3);
    rst_n = 1'b0;
    drive();
    run(1);
    chk("midrst_out_valid", LD'(out_valid), LD'(0));
    rst_n = 1'b1;
    drive();
    mark = log_ch.size();
    run(2);
    chk("midrst_restart", LD'(lch(mark)), LD'(0));
    run(30);

    // Random soak under the model.
    for (int i = 0; i < 800; i++) begin
      tick();
      for (int c = 0; c < NC; c++)
        if (src_q[c].size() < 3 && $urandom_range(0, 2) == 0) src_q[c].push_back(rand256());
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel   = 2'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      drive();
    end
    rst_n = 1'b1; mode = MODE_RR; out_ready = 1'b1;
    drive();
    run(40);

    // Three-channel instance: an out-of-range select never grants.
    @(posedge clk);
    #1;
    sel3 = 2'd0; in_data3 = {8'h33, 8'h22, 8'h5C}; in_valid3 = 3'b001;
    @(negedge clk);
    chk("ch3_ready_sel0", LD'(in_ready3), LD'(3'b001));
    @(posedge clk);
    #1;
    chk("ch3_out_valid", LD'(out_valid3), LD'(1));
    chk("ch3_out_data", LD'(out_data3), LD'(8'h5C));
    chk("ch3_out_ch", LD'(out_ch3), LD'(0));
    sel3 = 2'd3; in_valid3 = 3'b111;
    @(negedge clk);
    chk("ch3_oor_ready", LD'(in_ready3), LD'(0));
    @(posedge clk);
    #1;
    chk("ch3_oor_drained", LD'(out_valid3), LD'(0));
    @(negedge clk);
    chk("ch3_oor_ready2", LD'(in_ready3), LD'(0));
    @(posedge clk);
    #1;
    chk("ch3_oor_idle", LD'(out_valid3), LD'(0));
    sel3 = 2'd2;
    @(negedge clk);
    chk("ch3_ready_sel2", LD'(in_ready3), LD'(3'b100));
    @(posedge clk);
    #1;
    chk("ch3_sel2_data", LD'(out_data3), LD'(8'h33));
    chk("ch3_sel2_ch", LD'(out_ch3), LD'(2));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Registered N-channel stream multiplexer with valid/ready handshakes, the parametrised successor of the datapath 2-to-1 mux. It selects one of `NUM_CH` input streams per cycle, either by an external channel select (directed mode) or by a fair round-robin arbiter. The selected beat lands in a single output register that does not stall throughput. It sits between processing-element result producers and a shared downstream consumer, such as the writeback or memory port.

## Interface
- `LEN_DATA`, 256, width of each data beat.
- `NUM_CH`, 4, number of input channels (2..16).
- `LEN_SEL`, derived as `$clog2(NUM_CH)`, width of the channel index; a localparam, not overridable.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `mode` input 1: 0 = directed, 1 = round-robin.
- `sel` input `LEN_SEL`: channel index used in directed mode.
- `in_data` input `NUM_CH*LEN_DATA`: channel i occupies bits `[i*LEN_DATA +: LEN_DATA]`.
- `in_valid` input `NUM_CH`: per-channel beat valid.
- `in_ready` output `NUM_CH`: per-channel accept; at most one bit high per cycle.
- `out_data` output `LEN_DATA`: registered beat.
- `out_valid` output 1: `out_data` holds a beat.
- `out_ready` input 1: downstream accepts.
- `out_ch` output `LEN_SEL`: source channel of the beat currently in `out_data`.

## Operation
- **Transfer rule.** An input transfer on channel i occurs when `in_valid[i] && in_ready[i]`. An output transfer occurs when `out_valid && out_ready`.
- **Load enable.** `load = !out_valid || out_ready`. The output register may refill in the same cycle it drains.
- **Grant (combinational, from current inputs):**
  - Directed: the candidate is `sel`. `gnt_vld = (sel < NUM_CH) && in_valid[sel]`. An out-of-range `sel` never grants.
  - Round-robin: scan channels `ptr+1, ptr+2, …` modulo `NUM_CH`. The first channel with `in_valid` set wins. If no channel is valid, `gnt_vld = 0`.
- **Ready.** `in_ready[i] = load && gnt_vld && (gnt == i)`. Ready depends on `in_valid`; producers must not make `in_valid` depend on `in_ready`.
- **On an input transfer:** `out_data <= in_data[gnt]`, `out_ch <= gnt`, `out_valid <= 1`. In round-robin mode only, `ptr <= gnt`.
- **Drain without refill:** on an output transfer with no input transfer, `out_valid <= 0`. `out_data` and `out_ch` hold their last values.
- **Stall:** when `out_valid && !out_ready`, the output register holds, all `in_ready` are 0, and `ptr` holds.
- **Mode and select changes** take effect on the next grant evaluation. Switching mode does not reset `ptr`. A beat already in the output register is unaffected.
- **Unselected channels** are never dropped; they stay pending until granted.

## Timing
- **Reset values** (`rst_n` low at a rising edge): `out_valid = 0`, `out_data = 0`, `out_ch = 0`, `ptr = NUM_CH-1`, so channel 0 has first priority after reset. `in_ready` is all 0 while `rst_n` is low.
- **Reset mid-operation:** any beat held in the output register is discarded. An upstream beat presented during reset is not accepted.
- **Latency:** an input transfer in cycle t produces `out_valid = 1` with that data in cycle t+1.
- **Throughput:** 1 beat per cycle when `out_ready` is held high, with no bubbles.
- **Fairness:** in round-robin mode with all channels continuously valid, each channel is granted exactly once every `NUM_CH` transfers.
- **Clocking:** single clock domain. There is no combinational path from `in_data` to `out_data`. The only combinational paths from `out_ready`, `in_valid`, `mode` and `sel` go to `in_ready`.

## Structure
- **Shared package `mux_pkg`:** holds the mode encodings `MODE_DIRECT = 1'b0` and `MODE_RR = 1'b1`, and the maximum supported channel count `MAX_MUX_CH = 16`.
- **Sub-module `rr_arbiter`:** parameter `NUM_CH`. Inputs are `clk`, `rst_n`, `req[NUM_CH]` and `advance`. Outputs are `gnt[LEN_SEL]` and `gnt_vld`. It owns `ptr` and updates it only when `advance` is high.
- **Top level:** instantiates `rr_arbiter`, muxes its grant against `sel` under `mode`, and owns the output register.

## Test plan
1. **Reset check.** Hold `rst_n` low for 3 cycles with all `in_valid` high, then release. Required: `out_valid = 0`, `out_data = 0`, `out_ch = 0` and `in_ready = 0` during reset. The first grant after release is channel 0.
2. **Directed stream.** `mode = 0`, `sel = 2`, channel 2 streams 0xA0..0xA7, `out_ready = 1`. Required: 8 beats in order on consecutive cycles, 1-cycle latency, `out_ch = 2`. `in_ready[0,1,3]` stay 0.
3. **Round-robin fairness.** `mode = 1`, all 4 channels always valid, `out_ready = 1` for 12 cycles. Required: `out_ch` sequence 0,1,2,3,0,1,2,3,0,1,2,3.
4. **Backpressure.** Round-robin, channels 1 and 3 valid, `out_ready = 0` for cycles 2..5. Required: `out_data` and `out_ch` stable while stalled, no `in_ready` high, and no beat lost or duplicated after release.
5. **Sparse requests and mode switch.**
   - Round-robin: only channel 3 valid, then only channel 1. Required grants: 3, then 1, with `ptr = 1` afterwards.
   - Switch to `mode = 0` with `sel = 0` and channel 0 valid mid-stream. Required: the next accepted beat is from channel 0.
   - Set `sel` to an out-of-range value with `NUM_CH = 3`. Required: no grant, `out_valid` drops after the drain.
6. **Reset mid-stream.** Round-robin at full rate, assert `rst_n` low for one cycle. Required: the held beat is discarded, `out_valid = 0` the following cycle, and arbitration restarts at channel 0.
